// File: rtl/shared_mem_arbiter_pkg.sv
// Shared definitions for the shared-memory arbiter and its round-robin selector.
// Provides counter width, owner-index sizing and packed per-core field offsets.
package shared_mem_arbiter_pkg;

  localparam int ARB_COUNT_WIDTH = 32;

  // Index width for a core number; never narrower than one bit.
  function automatic int owner_width(input int num_cores);
    return (num_cores > 1) ? $clog2(num_cores) : 1;
  endfunction

  // LSB position of core idx's field in a vector packed at field_width per core.
  function automatic int field_lsb(input int idx, input int field_width);
    return idx * field_width;
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin picker: the search starts one past last_idx, ascends with wrap,
// and stops at the first set request bit. It produces a one-hot grant, an index and a valid flag.
module rr_priority_select
  import shared_mem_arbiter_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = owner_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_idx,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_valid
);

  logic [IW-1:0] cand;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = '0;
    for (int off = 1; off <= N; off++) begin
      cand = IW'((int'(last_idx) + off) % N);
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shared_mem_arbiter.sv
// Round-robin arbiter giving N cores same-cycle access to one shared memory port.
// Read data is broadcast; read_valid/read_owner tag it one cycle after the grant.
module shared_mem_arbiter
  import shared_mem_arbiter_pkg::*;
#(
  parameter int NUM_CORES  = 2,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_CORES-1:0]              core_request,
  input  logic [NUM_CORES*ADDR_WIDTH-1:0]   core_addr,
  input  logic [NUM_CORES-1:0]              core_wren,
  input  logic [NUM_CORES-1:0]              core_rden,
  input  logic [NUM_CORES*DATA_WIDTH-1:0]   core_write_val,
  output logic [NUM_CORES-1:0]              core_enable,
  output logic [DATA_WIDTH-1:0]             core_read_val,
  output logic [ADDR_WIDTH-1:0]             mem_addr,
  output logic                              mem_wren,
  output logic                              mem_rden,
  output logic [DATA_WIDTH-1:0]             mem_write_val,
  input  logic [DATA_WIDTH-1:0]             mem_read_val,
  output logic [owner_width(NUM_CORES)-1:0] read_owner,
  output logic                              read_valid,
  output logic [ARB_COUNT_WIDTH-1:0]        conflict_count,
  output logic [ARB_COUNT_WIDTH-1:0]        grant_count
);

  localparam int OW = owner_width(NUM_CORES);

  // Handshake: core_request is a level held by a stalled core until it sees core_enable
  // in the same cycle; a cycle with both high is one completed transfer (valid/ready).
  logic [OW-1:0]        last_grant;
  logic [NUM_CORES-1:0] sel_grant;
  logic [OW-1:0]        sel_idx;
  logic                 sel_valid;
  logic                 granted;

  rr_priority_select #(
    .N  (NUM_CORES),
    .IW (OW)
  ) u_select (
    .req         (core_request),
    .last_idx    (last_grant),
    .grant       (sel_grant),
    .grant_idx   (sel_idx),
    .grant_valid (sel_valid)
  );

  // No access can leak out while reset is asserted.
  assign granted     = sel_valid && !reset;
  assign core_enable = granted ? sel_grant : '0;

  always_comb begin
    mem_addr      = '0;
    mem_wren      = 1'b0;
    mem_rden      = 1'b0;
    mem_write_val = '0;
    if (granted) begin
      mem_addr      = core_addr[field_lsb(int'(sel_idx), ADDR_WIDTH) +: ADDR_WIDTH];
      mem_write_val = core_write_val[field_lsb(int'(sel_idx), DATA_WIDTH) +: DATA_WIDTH];
      mem_wren      = core_wren[sel_idx];
      mem_rden      = core_rden[sel_idx];
    end
  end

  assign core_read_val = mem_read_val;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant     <= OW'(NUM_CORES - 1);
      read_owner     <= '0;
      read_valid     <= 1'b0;
      conflict_count <= '0;
      grant_count    <= '0;
    end else begin
      read_valid <= mem_rden;
      if (granted) begin
        last_grant  <= sel_idx;
        read_owner  <= sel_idx;
        grant_count <= grant_count + 1'b1;
      end
      if ($countones(core_request) >= 2)
        conflict_count <= conflict_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Directed bench for shared_mem_arbiter: 2-core instance with a small memory model,
// plus a 4-core instance for the wrap-around priority case.
module tb_shared_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  int          checks = 0;
  int          errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- 2-core DUT ----------------
  logic [1:0]  core_request, core_wren, core_rden, core_enable;
  logic [31:0] core_addr, core_write_val;
  logic [15:0] core_read_val, mem_addr, mem_write_val, mem_read_val;
  logic        mem_wren, mem_rden, read_valid;
  logic [0:0]  read_owner;
  logic [31:0] conflict_count, grant_count;

  shared_mem_arbiter #(.NUM_CORES(2), .ADDR_WIDTH(16), .DATA_WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .core_request(core_request), .core_addr(core_addr),
    .core_wren(core_wren), .core_rden(core_rden), .core_write_val(core_write_val),
    .core_enable(core_enable), .core_read_val(core_read_val),
    .mem_addr(mem_addr), .mem_wren(mem_wren), .mem_rden(mem_rden),
    .mem_write_val(mem_write_val), .mem_read_val(mem_read_val),
    .read_owner(read_owner), .read_valid(read_valid),
    .conflict_count(conflict_count), .grant_count(grant_count)
  );

  // Shared memory model: write at edge, read data one cycle after mem_rden.
  logic [15:0] mem_arr [0:65535];
  always @(posedge clk) begin
    if (mem_wren) mem_arr[mem_addr] <= mem_write_val;
    if (mem_rden) mem_read_val <= mem_arr[mem_addr];
  end

  // ---------------- 4-core DUT ----------------
  logic [3:0]  req4, enable4;
  logic [63:0] addr4, wval4;
  logic [15:0] rval4, maddr4, mwval4;
  logic        mwren4, mrden4, rvalid4;
  logic [1:0]  rowner4;
  logic [31:0] conf4, gcnt4;

  shared_mem_arbiter #(.NUM_CORES(4), .ADDR_WIDTH(16), .DATA_WIDTH(16)) dut4 (
    .clk(clk), .reset(reset),
    .core_request(req4), .core_addr(addr4),
    .core_wren(4'b0000), .core_rden(4'b0000), .core_write_val(wval4),
    .core_enable(enable4), .core_read_val(rval4),
    .mem_addr(maddr4), .mem_wren(mwren4), .mem_rden(mrden4),
    .mem_write_val(mwval4), .mem_read_val(16'h0000),
    .read_owner(rowner4), .read_valid(rvalid4),
    .conflict_count(conf4), .grant_count(gcnt4)
  );

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [1:0] req, input logic [15:0] a0, input logic [15:0] a1,
                       input logic [1:0] wr, input logic [1:0] rd,
                       input logic [15:0] w0, input logic [15:0] w1);
    core_request   = req;
    core_addr      = {a1, a0};
    core_wren      = wr;
    core_rden      = rd;
    core_write_val = {w1, w0};
  endtask

  task automatic idle();
    drive(2'b00, 16'h0, 16'h0, 2'b00, 2'b00, 16'h0, 16'h0);
  endtask

  // Advance one clock and settle away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    mem_arr[16'h4010] = 16'hBEEF;
    mem_arr[16'h8000] = 16'h0000;
    mem_read_val = 16'h0000;
    req4 = 4'b0000; addr4 = '0; wval4 = '0;
    reset = 1'b1;
    idle();
    tick(); tick();

    // Reset state, including requests held during reset.
    check("rst_enable", {30'd0, core_enable}, 32'd0);
    check("rst_read_valid", {31'd0, read_valid}, 32'd0);
    check("rst_read_owner", {31'd0, read_owner}, 32'd0);
    check("rst_conflict", conflict_count, 32'd0);
    check("rst_grants", grant_count, 32'd0);
    drive(2'b11, 16'h8000, 16'h8000, 2'b11, 2'b00, 16'h1234, 16'h5678);
    #1;
    check("rst_enable_req", {30'd0, core_enable}, 32'd0);
    check("rst_no_write", {31'd0, mem_wren}, 32'd0);
    idle();
    tick();
    reset = 1'b0;

    // Single requester: core 1 reads 0x4010.
    drive(2'b10, 16'h0, 16'h4010, 2'b00, 2'b10, 16'h0, 16'h0);
    #1;
    check("single_enable", {30'd0, core_enable}, 32'h2);
    check("single_addr", {16'd0, mem_addr}, 32'h4010);
    check("single_rden", {31'd0, mem_rden}, 32'd1);
    tick();
    idle();
    check("single_rdata", {16'd0, core_read_val}, 32'hBEEF);
    check("single_owner", {31'd0, read_owner}, 32'd1);
    check("single_rvalid", {31'd0, read_valid}, 32'd1);
    check("single_grants", grant_count, 32'd1);
    tick();
    check("single_rvalid_drop", {31'd0, read_valid}, 32'd0);

    // Continuous contention from reset: 0,1,0,1,0,1.
    reset = 1'b1;
    #2;
    reset = 1'b0;
    drive(2'b11, 16'h0, 16'h0, 2'b00, 2'b00, 16'h0, 16'h0);
    #1;
    check("rr_c0", {30'd0, core_enable}, 32'h1); tick();
    check("rr_c1", {30'd0, core_enable}, 32'h2); tick();
    check("rr_c2", {30'd0, core_enable}, 32'h1); tick();
    check("rr_c3", {30'd0, core_enable}, 32'h2); tick();
    check("rr_c4", {30'd0, core_enable}, 32'h1); tick();
    check("rr_c5", {30'd0, core_enable}, 32'h2); tick();
    idle();
    check("rr_conflicts", conflict_count, 32'd6);
    check("rr_grants", grant_count, 32'd6);

    // Simultaneous writes to 0x8000: core 0 then core 1.
    drive(2'b11, 16'h8000, 16'h8000, 2'b11, 2'b00, 16'h1111, 16'h2222);
    #1;
    check("wr_first_enable", {30'd0, core_enable}, 32'h1);
    check("wr_first_data", {16'd0, mem_write_val}, 32'h1111);
    check("wr_first_wren", {31'd0, mem_wren}, 32'd1);
    tick();
    drive(2'b10, 16'h0, 16'h8000, 2'b10, 2'b00, 16'h0, 16'h2222);
    #1;
    check("wr_second_enable", {30'd0, core_enable}, 32'h2);
    check("wr_second_data", {16'd0, mem_write_val}, 32'h2222);
    tick();
    drive(2'b01, 16'h8000, 16'h0, 2'b00, 2'b01, 16'h0, 16'h0);
    #1;
    check("wr_readback_enable", {30'd0, core_enable}, 32'h1);
    tick();
    idle();
    check("wr_final_value", {16'd0, core_read_val}, 32'h2222);
    check("wr_readback_owner", {31'd0, read_owner}, 32'd0);
    check("wr_readback_valid", {31'd0, read_valid}, 32'd1);

    // Idle gap: core 1 granted, 3 idle cycles, then contention goes to core 0.
    drive(2'b10, 16'h0, 16'h0, 2'b00, 2'b00, 16'h0, 16'h0);
    #1;
    check("idle_c1_enable", {30'd0, core_enable}, 32'h2);
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      #1;
      check("idle_enable", {30'd0, core_enable}, 32'd0);
      check("idle_no_access", {14'd0, mem_wren, mem_rden, mem_addr}, 32'd0);
      tick();
    end
    drive(2'b11, 16'h0, 16'h0, 2'b00, 2'b00, 16'h0, 16'h0);
    #1;
    check("idle_then_c0", {30'd0, core_enable}, 32'h1);
    tick();

    // Reset arriving the cycle after a granted read.
    drive(2'b10, 16'h0, 16'h4010, 2'b00, 2'b10, 16'h0, 16'h0);
    #1;
    check("rstmid_enable", {30'd0, core_enable}, 32'h2);
    tick();
    check("rstmid_rvalid_before", {31'd0, read_valid}, 32'd1);
    drive(2'b11, 16'h8000, 16'h8000, 2'b11, 2'b00, 16'hDEAD, 16'hDEAD);
    reset = 1'b1;
    #1;
    check("rstmid_rvalid", {31'd0, read_valid}, 32'd0);
    check("rstmid_conflict", conflict_count, 32'd0);
    check("rstmid_grants", grant_count, 32'd0);
    check("rstmid_no_write", {31'd0, mem_wren}, 32'd0);
    tick();
    reset = 1'b0;
    drive(2'b11, 16'h0, 16'h0, 2'b00, 2'b00, 16'h0, 16'h0);
    #1;
    check("rstmid_first_c0", {30'd0, core_enable}, 32'h1);
    tick();
    idle();
    check("rst_kept_mem", {16'd0, mem_arr[16'h8000]}, 32'h2222);

    // Four cores: move pointer to 1, then 4'b1010 grants 3 then 1.
    req4 = 4'b0010;
    #1;
    check("n4_setup", {28'd0, enable4}, 32'h2);
    tick();
    req4 = 4'b1010;
    #1;
    check("n4_wrap_c3", {28'd0, enable4}, 32'h8);
    tick();
    check("n4_owner", {30'd0, rowner4}, 32'd3);
    check("n4_then_c1", {28'd0, enable4}, 32'h2);
    tick();
    req4 = 4'b0000;
    check("n4_conflicts", conf4, 32'd2);
    check("n4_grants", gcnt4, 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
